rcv_shift_controller: RTL and testbench

- Downstream stage of the UART receive baud counter / start-bit detector.
- Consumes StartDetect and BaudClock from the detector, and drives its Shift and Idle inputs.
- Samples RxD at mid-bit, assembles the data word LSB-first, checks the stop bit, and presents the byte to the memory-mapped IO read side with a valid/read handshake and overrun flag.

---
 rtl/uart_pkg.sv | 7 +
 rtl/rcv_edge_detect.sv | 14 +
 rtl/rcv_shift_controller.sv | 91 +++++++++
 tb/tb_rcv_shift_controller.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and sizing constants for the UART receive path
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DATA_BITS_DEFAULT = 8;
    localparam int MAX_DATA_BITS = 8;
    localparam int CNT_W = $clog2(MAX_DATA_BITS + 1);
endpackage

// File: rtl/rcv_edge_detect.sv
// rcv_edge_detect: registers a level and emits a one-cycle pulse on its rising edge
module rcv_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic tick
);
    logic level_d;
    // delayed copy of the level, updated every cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) level_d <= 1'b0;
        else level_d <= level;
    assign tick = level & ~level_d;
endmodule

// File: rtl/rcv_shift_controller.sv
// rcv_shift_controller: mid-bit sampler, LSB-first word assembly, stop/parity check and read handshake
// Optional parity checking is enabled by defining RCV_PARITY_EN.
module rcv_shift_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_d,
    input  logic                 start_detect,
    input  logic                 baud_clock,
    input  logic                 read,
    output logic                 shift,
    output logic                 idle,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 parity_error
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);
    state_t               state, state_nx;
    logic                 tick, complete;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] sreg;

    rcv_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (baud_clock),
        .tick  (tick)
    );

    assign idle     = state == IDLE;
    assign complete = tick && state == STOP && rx_d;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next-state decode; ticks in IDLE and start_detect outside IDLE are ignored
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_detect ? START : IDLE;
            START:   if (tick) state_nx = rx_d ? IDLE : DATA;
`ifdef RCV_PARITY_EN
            DATA:    if (tick && cnt == LAST) state_nx = PARITY;
            PARITY:  if (tick) state_nx = STOP;
`else
            DATA:    if (tick && cnt == LAST) state_nx = STOP;
`endif
            STOP:    if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // bit counter, shift register, sample pulse and the read-side handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt           <= '0;
            sreg          <= '0;
            shift         <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            shift <= tick && state != IDLE;
            if (state == IDLE) cnt <= '0;
            else if (state == DATA && tick) begin
                sreg <= {rx_d, sreg[DATA_BITS-1:1]};
                cnt  <= cnt + CNT_W'(1);
            end
            if (complete) rx_data <= sreg;
            rx_valid      <= complete ? 1'b1 : read ? 1'b0 : rx_valid;
            overrun       <= read ? 1'b0 : (complete && rx_valid) ? 1'b1 : overrun;
            framing_error <= (tick && state == STOP && !rx_d) ? 1'b1 : read ? 1'b0 : framing_error;
        end

`ifdef RCV_PARITY_EN
    // even parity over the data word plus the received parity bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) parity_error <= 1'b0;
        else parity_error <= (tick && state == PARITY && ^{rx_d, sreg}) ? 1'b1 : read ? 1'b0 : parity_error;
`else
    assign parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_rcv_shift_controller.sv
// tb_rcv_shift_controller: directed and random frames checked against a frame-level reference model
module tb_rcv_shift_controller;
    localparam int DW = 8;
`ifdef RCV_PARITY_EN
    localparam int NSHIFT = DW + 3;
`else
    localparam int NSHIFT = DW + 2;
`endif
    logic          clk = 1'b0, rst_n = 1'b0, rx_d = 1'b1, start_detect = 1'b0, baud_clock = 1'b0, read = 1'b0;
    logic          shift, idle, rx_valid, framing_error, overrun, parity_error;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] m_data;
    logic          m_valid, m_fe, m_ovr, m_pe;
    int            ncmp = 0, nfail = 0, shift_cnt = 0;

    rcv_shift_controller #(.DATA_BITS(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_d          (rx_d),
        .start_detect  (start_detect),
        .baud_clock    (baud_clock),
        .read          (read),
        .shift         (shift),
        .idle          (idle),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (shift === 1'b1) shift_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, 32'(rx_data), 32'(m_data));
        check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, ".fe"}, 32'(framing_error), 32'(m_fe));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".pe"}, 32'(parity_error), 32'(m_pe));
        check({tag, ".idle"}, 32'(idle), 32'(1));
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 0; m_fe = 0; m_ovr = 0; m_pe = 0;
    endtask

    // one bit time of 16 clocks; baud_clock mimics detector Count[3], rising at mid-bit
    task automatic send_bit(input logic lo, input logic hi, input logic sd, input logic rd);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rx_d = (c < 8) ? lo : hi;
            baud_clock = (c >= 8);
            start_detect = sd && (c < 8);
            read = rd && (c == 8);
        end
        read = 1'b0;
    endtask

    task automatic gap_read();
        @(negedge clk); read = 1'b1;
        @(negedge clk); read = 1'b0;
        m_valid = 0; m_fe = 0; m_ovr = 0; m_pe = 0;
    endtask

    // a whole frame, then the frame-level effect on the expected outputs
    task automatic send_frame(input string tag, input logic [DW-1:0] d, input logic stop, input logic pbit, input logic rd);
        int base;
        base = shift_cnt;
        send_bit(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i], d[i], 1'b0, 1'b0);
`ifdef RCV_PARITY_EN
        send_bit(pbit, pbit, 1'b0, 1'b0);
        if (^{d, pbit}) m_pe = 1;
`endif
        send_bit(stop, stop, 1'b0, rd);
        if (rd) begin m_valid = 0; m_fe = 0; m_ovr = 0; m_pe = 0; end
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_data = d; m_valid = 1;
        end else m_fe = 1;
        check({tag, ".shifts"}, 32'(shift_cnt - base), 32'(NSHIFT));
        check_all(tag);
    endtask

    initial begin
        int base;
        logic [DW-1:0] d;
        logic st, rd;
        model_reset();
        #1;
        check("rst.shift", 32'(shift), 32'(0));
        check_all("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);

        send_frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        gap_read();
        check_all("read_a5");

        base = shift_cnt;
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        check("false.shifts", 32'(shift_cnt - base), 32'(1));
        check_all("false");

        send_frame("3c_bad_stop", 8'h3C, 1'b0, 1'b0, 1'b0);
        gap_read();
        check_all("fe_clear");

        send_frame("11", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame("22_ovr", 8'h22, 1'b1, 1'b0, 1'b0);
        send_frame("33_rd_stop", 8'h33, 1'b1, 1'b0, 1'b1);

        send_bit(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid.idle", 32'(idle), 32'(0));
        @(negedge clk); rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.shift", 32'(shift), 32'(0));
        check_all("midrst");
        @(negedge clk); rst_n = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame("5a", 8'h5A, 1'b1, 1'b0, 1'b0);
`ifdef RCV_PARITY_EN
        gap_read();
        send_frame("07_par", 8'h07, 1'b1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 30; n++) begin
            d = DW'($urandom);
            st = ($urandom_range(0, 7) != 0);
            rd = ($urandom_range(0, 3) == 0);
            send_frame("rand", d, st, 1'($urandom), rd);
            if ($urandom_range(0, 2) == 0) gap_read();
            send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
